axi_bellek_hakemi: RTL and testbench
====================================

Name: axi_bellek_hakemi

Overview:
- Two-port arbiter and sequencer that shares one AXI4-Lite master interface between two memory requesters: port 0 is the load/store unit, port 1 is the peripheral/DMA side.
- Accepts one MEM_LB/LH/LW/SB/SH/SW command at a time and runs the full AR/R or AW+W/B transaction.
- Returns a one-cycle response to the granted port.
- Sits between the core memory stage and the SoC interconnect.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority to port 0.
- TIMEOUT_CYC, 256, cycle limit per transaction; used only when AXI_TIMEOUT_EN is defined.

Ports:
- axi_aclk_i  in  1  single clock
- axi_aresetn_i  in  1  synchronous, active-high reset (1 = reset)
- req0_valid_i / req1_valid_i  in  1  command valid
- req0_ready_o / req1_ready_o  out  1  command accepted this cycle
- req0_op_i / req1_op_i  in  3  MEM_* code from operations.vh
- req0_addr_i / req1_addr_i  in  32  byte address
- req0_wdata_i / req1_wdata_i  in  32  store data, right-aligned
- rsp0_valid_o / rsp1_valid_o  out  1  one-cycle response pulse
- rsp0_rdata_o / rsp1_rdata_o  out  32  load data, right-aligned (byte lane shifted down), zero-filled above the access size
- rsp0_err_o / rsp1_err_o  out  1  error flag, qualified by rsp valid
- axi_araddr_o  out 32; axi_arvalid_o  out 1; axi_arready_i  in 1
- axi_rvalid_i  in 1; axi_rready_o  out 1; axi_rdata_i  in 32; axi_rresp_i  in 2
- axi_awaddr_o  out 32; axi_awvalid_o  out 1; axi_awready_i  in 1
- axi_wdata_o  out 32; axi_wstrb_o  out 4; axi_wvalid_o  out 1; axi_wready_i  in 1
- axi_bvalid_i  in 1; axi_bready_o  out 1; axi_bresp_i  in 2

Behaviour:
- Reset:
  - All valid, ready and err outputs are 0; rdata, addresses, wdata and wstrb are 0.
  - State is IDLE; last_grant = 1, so port 0 wins first.
- States: IDLE, AR, R, WR (AW and/or W pending), B, RSP.
- IDLE, grant:
  - Grant decision is combinational.
  - PRIO_MODE=0: if both ports are valid, grant the port != last_grant.
  - PRIO_MODE=1: port 0 always wins.
  - reqN_ready_o = 1 only in IDLE, and only for the granted port.
  - On the handshake, latch port id, op, addr and wdata, and update last_grant.
- Validation at accept:
  - Unknown op → error.
  - LH/SH with addr[0]=1 → error.
  - LW/SW with addr[1:0]≠0 → error.
  - On error: go to RSP with err=1 and issue no AXI traffic.
- Load: AR (arvalid=1, araddr = addr & ~3) until arready, then R.
- R:
  - rready=1; wait for rvalid.
  - Capture rdata >> 8*addr[1:0], masked to 8/16/32 bits.
  - err = (rresp≠0).
  - Go to RSP.
- Store:
  - WR raises awvalid and wvalid together.
  - Each valid drops independently on its own handshake; leave WR once both have completed, in either order or in the same cycle.
  - awaddr = addr & ~3.
  - wdata = byte replicated (SB), halfword replicated (SH) or the full word (SW).
  - wstrb = 0001, 0011 or 1111, shifted left by addr[1:0].
- B: bready=1; on bvalid, err = (bresp≠0), go to RSP.
- RSP:
  - rspN_valid_o = 1 for exactly one cycle on the latched port, with rdata/err; rdata is 0 for stores.
  - Then IDLE; the next grant is possible in the following cycle.
- Minimum latency with slave ready every cycle: load is accept→AR 1, R 1, RSP 1 = rsp 3 cycles after accept; store is the same.
- Outputs: all AXI outputs are registered or decoded from state only; there are no combinational paths from AXI inputs to AXI outputs.
- Ordering: one outstanding transaction; the non-granted requester holds valid and waits (no starvation in PRIO_MODE=0).
- Reset mid-transaction: immediately return to IDLE with all valids low; the in-flight response is discarded. The slave must be reset together with this block.
- Inputs change while not ready: ignored; only the values captured at the handshake are used.

Optional Feature:
- AXI_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to AR/WR/R/B and increments each cycle in those states.
  - At TIMEOUT_CYC-1 with no completing handshake, drop all AXI valids, go to RSP with err=1, then IDLE.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Shared package/header:
  - MEM_* op codes (operations.vh, reused)
  - state encoding localparams
  - AXI_RESP_OKAY=2'b00
  - PORT_LSU=0, PORT_DMA=1
- One natural sub-module, axi_bayt_hizalayici (combinational): op+addr+wdata/rdata → wstrb, aligned wdata, shifted/masked rdata, misalign error.

Test Plan:
- Port 0 LW addr 0x100; slave returns rdata 0xDEADBEEF, rresp 0 → rsp0_valid 3 cycles after accept, rdata 0xDEADBEEF, err 0.
- Port 1 SB addr 0x203, wdata 0x000000A5; awready two cycles before wready → wstrb 1000, wdata 0xA5A5A5A5, awaddr 0x200; rsp1 after B, err 0.
- Both ports valid continuously with PRIO_MODE=0 → grants alternate 0,1,0,1; with PRIO_MODE=1 → port 1 is never granted while port 0 is valid.
- Port 0 LH addr 0x101 → rsp0 err=1 two cycles after accept, arvalid/awvalid never asserted.
- LB addr 0x302, rdata 0x11223344, rresp 2'b10 → rdata 0x00000022, err 1.
- AXI_TIMEOUT_EN, TIMEOUT_CYC=8, arready held 0 → arvalid drops after 8 cycles, rsp err 1; reset asserted mid-WR → all valids 0 next cycle, no rsp.

Source files
------------

// File: rtl/axi_bellek_hakemi_pkg.sv
// Shared definitions for the two-port AXI4-Lite memory arbiter:
// memory op codes, AXI response codes, port ids and sequencer states.
package axi_bellek_hakemi_pkg;

  localparam logic [2:0] MEM_LB = 3'd0;
  localparam logic [2:0] MEM_LH = 3'd1;
  localparam logic [2:0] MEM_LW = 3'd2;
  localparam logic [2:0] MEM_SB = 3'd4;
  localparam logic [2:0] MEM_SH = 3'd5;
  localparam logic [2:0] MEM_SW = 3'd6;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/axi_bellek_hakemi_hizalayici.sv
// axi_bayt_hizalayici: combinational byte-lane aligner. Builds store strobes and
// replicated write data, extracts right-aligned load data, and flags bad accesses.
module axi_bayt_hizalayici
  import axi_bellek_hakemi_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_aligned,
  output logic        access_err
);

  logic [31:0] rdata_shifted;

  assign rdata_shifted = rdata >> {addr_lo, 3'b000};

  // Unknown op codes are reported through the same error flag as misalignment
  always_comb begin
    wstrb         = 4'b0000;
    wdata_aligned = 32'h0;
    rdata_aligned = 32'h0;
    access_err    = 1'b0;
    case (op)
      MEM_LB: rdata_aligned = {24'h0, rdata_shifted[7:0]};
      MEM_LH: begin
        rdata_aligned = {16'h0, rdata_shifted[15:0]};
        access_err    = addr_lo[0];
      end
      MEM_LW: begin
        rdata_aligned = rdata_shifted;
        access_err    = (addr_lo != 2'b00);
      end
      MEM_SB: begin
        wstrb         = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
      end
      MEM_SH: begin
        wstrb         = 4'b0011 << addr_lo;
        wdata_aligned = {2{wdata[15:0]}};
        access_err    = addr_lo[0];
      end
      MEM_SW: begin
        wstrb         = 4'b1111;
        wdata_aligned = wdata;
        access_err    = (addr_lo != 2'b00);
      end
      default: access_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_bellek_hakemi.sv
// Two-port arbiter/sequencer sharing one AXI4-Lite master between the LSU and DMA side.
// Optional per-transaction timeout is enabled by defining AXI_TIMEOUT_EN.
module axi_bellek_hakemi
  import axi_bellek_hakemi_pkg::*;
#(
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        axi_aclk_i,
  input  logic        axi_aresetn_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [2:0]  req0_op_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [2:0]  req1_op_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_rdata_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_rdata_o,
  output logic        rsp1_err_o,
  output logic [31:0] axi_araddr_o,
  output logic        axi_arvalid_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  output logic        axi_rready_o,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  output logic [31:0] axi_awaddr_o,
  output logic        axi_awvalid_o,
  input  logic        axi_awready_i,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wvalid_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  output logic        axi_bready_o,
  input  logic [1:0]  axi_bresp_i
);

  state_t      state_q, state_d;
  logic        port_q, last_grant_q, grant_port, accept;
  logic [2:0]  op_q, grant_op;
  logic [31:0] addr_q, wdata_q, grant_addr, grant_wdata;
  logic        aw_done_q, w_done_q, wr_complete, timeout;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_rdata;
  logic        al_err;

  axi_bayt_hizalayici u_hizalayici (
    .op            (op_q),
    .addr_lo       (addr_q[1:0]),
    .wdata         (wdata_q),
    .rdata         (axi_rdata_i),
    .wstrb         (al_wstrb),
    .wdata_aligned (al_wdata),
    .rdata_aligned (al_rdata),
    .access_err    (al_err)
  );

  // Contention only matters when both ports ask at once
  always_comb begin
    if (req0_valid_i && req1_valid_i && (PRIO_MODE == 0))
      grant_port = ~last_grant_q;
    else
      grant_port = req0_valid_i ? PORT_LSU : PORT_DMA;
  end

  assign req0_ready_o = (state_q == ST_IDLE) && req0_valid_i && (grant_port == PORT_LSU);
  assign req1_ready_o = (state_q == ST_IDLE) && req1_valid_i && (grant_port == PORT_DMA);
  assign accept       = req0_ready_o || req1_ready_o;
  assign grant_op     = grant_port ? req1_op_i    : req0_op_i;
  assign grant_addr   = grant_port ? req1_addr_i  : req0_addr_i;
  assign grant_wdata  = grant_port ? req1_wdata_i : req0_wdata_i;

  // Bad accesses are caught from the latched command, so no valid is ever raised for them
  assign axi_arvalid_o = (state_q == ST_AR) && !al_err;
  assign axi_awvalid_o = (state_q == ST_WR) && !al_err && !aw_done_q;
  assign axi_wvalid_o  = (state_q == ST_WR) && !al_err && !w_done_q;
  assign axi_rready_o  = (state_q == ST_R);
  assign axi_bready_o  = (state_q == ST_B);
  assign axi_araddr_o  = {addr_q[31:2], 2'b00};
  assign axi_awaddr_o  = {addr_q[31:2], 2'b00};
  assign axi_wdata_o   = al_wdata;
  assign axi_wstrb_o   = al_wstrb;
  assign wr_complete   = (aw_done_q || axi_awready_i) && (w_done_q || axi_wready_i);

  assign rsp0_valid_o = (state_q == ST_RSP) && (port_q == PORT_LSU);
  assign rsp1_valid_o = (state_q == ST_RSP) && (port_q == PORT_DMA);
  assign rsp0_rdata_o = rsp0_valid_o ? rsp_rdata_q : 32'h0;
  assign rsp1_rdata_o = rsp1_valid_o ? rsp_rdata_q : 32'h0;
  assign rsp0_err_o   = rsp0_valid_o && rsp_err_q;
  assign rsp1_err_o   = rsp1_valid_o && rsp_err_q;

`ifdef AXI_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        in_bus_state;

  assign in_bus_state = (state_q == ST_AR) || (state_q == ST_R) ||
                        (state_q == ST_WR) || (state_q == ST_B);
  assign timeout      = in_bus_state && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i)
      tmo_cnt_q <= 16'h0;
    else if (state_d != state_q)
      tmo_cnt_q <= 16'h0;
    else if (in_bus_state)
      tmo_cnt_q <= tmo_cnt_q + 16'h1;
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = op_is_store(grant_op) ? ST_WR : ST_AR;
      ST_AR: begin
        if (al_err)             state_d = ST_RSP;
        else if (axi_arready_i) state_d = ST_R;
        else if (timeout)       state_d = ST_RSP;
      end
      ST_R:    if (axi_rvalid_i || timeout) state_d = ST_RSP;
      ST_WR: begin
        if (al_err)           state_d = ST_RSP;
        else if (wr_complete) state_d = ST_B;
        else if (timeout)     state_d = ST_RSP;
      end
      ST_B:    if (axi_bvalid_i || timeout) state_d = ST_RSP;
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture at the handshake, then response data/error collection per phase
  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i) begin
      port_q       <= PORT_LSU;
      last_grant_q <= PORT_DMA;
      op_q         <= 3'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          port_q       <= grant_port;
          last_grant_q <= grant_port;
          op_q         <= grant_op;
          addr_q       <= grant_addr;
          wdata_q      <= grant_wdata;
          aw_done_q    <= 1'b0;
          w_done_q     <= 1'b0;
          rsp_rdata_q  <= 32'h0;
          rsp_err_q    <= 1'b0;
        end
        ST_AR: if (al_err || (!axi_arready_i && timeout)) rsp_err_q <= 1'b1;
        ST_R: begin
          if (axi_rvalid_i) begin
            rsp_rdata_q <= al_rdata;
            rsp_err_q   <= (axi_rresp_i != AXI_RESP_OKAY);
          end else if (timeout) begin
            rsp_err_q <= 1'b1;
          end
        end
        ST_WR: begin
          if (axi_awvalid_o && axi_awready_i) aw_done_q <= 1'b1;
          if (axi_wvalid_o && axi_wready_i)   w_done_q  <= 1'b1;
          if (al_err || (!wr_complete && timeout)) rsp_err_q <= 1'b1;
        end
        ST_B: begin
          if (axi_bvalid_i)  rsp_err_q <= (axi_bresp_i != AXI_RESP_OKAY);
          else if (timeout)  rsp_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bellek_hakemi.sv
// Directed bench for axi_bellek_hakemi: a reactive AXI slave with per-channel delays,
// hand-computed expectations, plus a fixed-priority instance for the arbitration check.
module tb_axi_bellek_hakemi;
  import axi_bellek_hakemi_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  axi_bellek_hakemi #(.PRIO_MODE(0), .TIMEOUT_CYC(8)) dut (
    .axi_aclk_i(clock), .axi_aresetn_i(reset),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
    .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
    .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
    .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
    .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
    .axi_araddr_o(araddr), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
    .axi_awaddr_o(awaddr), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bvalid_i(bvalid), .axi_bready_o(bready), .axi_bresp_i(bresp)
  );

  // Fixed-priority instance with an always-ready slave tied off
  logic        p_req0_valid, p_req1_valid, p_ready0, p_ready1;
  logic        p_rsp0_valid, p_rsp0_err, p_rsp1_valid, p_rsp1_err;
  logic [31:0] p_rsp0_rdata, p_rsp1_rdata, p_araddr, p_awaddr, p_wdata;
  logic        p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
  logic [3:0]  p_wstrb;

  axi_bellek_hakemi #(.PRIO_MODE(1), .TIMEOUT_CYC(8)) dut_prio (
    .axi_aclk_i(clock), .axi_aresetn_i(reset),
    .req0_valid_i(p_req0_valid), .req0_ready_o(p_ready0), .req0_op_i(MEM_LW),
    .req0_addr_i(32'h0), .req0_wdata_i(32'h0),
    .req1_valid_i(p_req1_valid), .req1_ready_o(p_ready1), .req1_op_i(MEM_LW),
    .req1_addr_i(32'h4), .req1_wdata_i(32'h0),
    .rsp0_valid_o(p_rsp0_valid), .rsp0_rdata_o(p_rsp0_rdata), .rsp0_err_o(p_rsp0_err),
    .rsp1_valid_o(p_rsp1_valid), .rsp1_rdata_o(p_rsp1_rdata), .rsp1_err_o(p_rsp1_err),
    .axi_araddr_o(p_araddr), .axi_arvalid_o(p_arvalid), .axi_arready_i(1'b1),
    .axi_rvalid_i(1'b1), .axi_rready_o(p_rready), .axi_rdata_i(32'h0), .axi_rresp_i(2'b00),
    .axi_awaddr_o(p_awaddr), .axi_awvalid_o(p_awvalid), .axi_awready_i(1'b1),
    .axi_wdata_o(p_wdata), .axi_wstrb_o(p_wstrb), .axi_wvalid_o(p_wvalid), .axi_wready_i(1'b1),
    .axi_bvalid_i(1'b1), .axi_bready_o(p_bready), .axi_bresp_i(2'b00)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reactive slave: each channel becomes ready after a programmable number of valid cycles
  int          ar_delay = 0, aw_delay = 0, w_delay = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int          arvalid_cycles = 0, awvalid_cycles = 0;
  logic [31:0] s_rdata = 32'h0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;

  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clock); #2;
      if (arvalid) begin
        arvalid_cycles++;
        arready = (ar_cnt >= ar_delay);
        if (arready) seen_araddr = araddr;
        ar_cnt++;
      end else begin
        arready = 0; ar_cnt = 0;
      end
      if (awvalid) begin
        awvalid_cycles++;
        awready = (aw_cnt >= aw_delay);
        if (awready) seen_awaddr = awaddr;
        aw_cnt++;
      end else begin
        awready = 0; aw_cnt = 0;
      end
      if (wvalid) begin
        wready = (w_cnt >= w_delay);
        if (wready) begin seen_wdata = wdata; seen_wstrb = wstrb; end
        w_cnt++;
      end else begin
        wready = 0; w_cnt = 0;
      end
      rvalid = rready;
      rdata  = rready ? s_rdata : 32'h0;
      rresp  = rready ? s_rresp : 2'b00;
      bvalid = bready;
      bresp  = bready ? s_bresp : 2'b00;
    end
  end

  bit grant_q[$];
  int p1_while_p0 = 0, p0_grants = 0;

  initial begin
    forever begin
      @(negedge clock); #3;
      if (req0_ready) grant_q.push_back(1'b0);
      if (req1_ready) grant_q.push_back(1'b1);
      if (p_req0_valid && p_ready1) p1_while_p0++;
      if (p_ready0) p0_grants++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input string tag, input logic port, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output logic er, output int lat,
                               output logic other_rsp);
    logic accepted, got;
    accepted = 0; got = 0; other_rsp = 0; lat = 0; rd = 0; er = 0;
    arvalid_cycles = 0; awvalid_cycles = 0;
    seen_araddr = 0; seen_awaddr = 0; seen_wdata = 0; seen_wstrb = 0;
    @(negedge clock);
    if (port) begin
      req1_valid = 1; req1_op = op; req1_addr = addr; req1_wdata = wd;
    end else begin
      req0_valid = 1; req0_op = op; req0_addr = addr; req0_wdata = wd;
    end
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1;
      accepted = port ? req1_ready : req0_ready;
      @(negedge clock);
    end
    req0_valid = 0; req1_valid = 0;
    req0_addr = 32'hFFFF_FFFF; req1_addr = 32'hFFFF_FFFF;
    req0_wdata = 32'h5A5A_5A5A; req1_wdata = 32'h5A5A_5A5A;
    checkOutput({tag, " accepted"}, accepted, 1);
    if (accepted) begin
      lat = 1;
      for (int i = 0; i < 40 && !got; i++) begin
        if (port ? rsp0_valid : rsp1_valid) other_rsp = 1;
        if (port ? rsp1_valid : rsp0_valid) begin
          got = 1;
          rd  = port ? rsp1_rdata : rsp0_rdata;
          er  = port ? rsp1_err : rsp0_err;
        end else begin
          @(negedge clock);
          lat++;
        end
      end
      checkOutput({tag, " rsp_seen"}, got, 1);
      if (got) begin
        @(negedge clock);
        checkOutput({tag, " rsp_one_cycle"}, port ? rsp1_valid : rsp0_valid, 0);
      end
    end
  endtask

  logic [31:0] rd;
  logic        er, oth, seen;
  int          lat;

  initial begin
    reset = 1;
    req0_valid = 0; req0_op = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_op = 0; req1_addr = 0; req1_wdata = 0;
    p_req0_valid = 0; p_req1_valid = 0;
    repeat (3) @(negedge clock);
    checkOutput("rst valids", {arvalid, awvalid, wvalid, rready, bready, req0_ready, req1_ready,
                               rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
    checkOutput("rst araddr", araddr, 0);
    checkOutput("rst awaddr", awaddr, 0);
    checkOutput("rst wdata", wdata, 0);
    checkOutput("rst wstrb", wstrb, 0);
    checkOutput("rst rdata", rsp0_rdata | rsp1_rdata, 0);
    reset = 0;
    @(negedge clock);

    s_rdata = 32'hDEADBEEF; s_rresp = 2'b00;
    applyStimulus("lw_p0", 0, MEM_LW, 32'h100, 32'h0, rd, er, lat, oth);
    checkOutput("lw_p0 rdata", rd, 32'hDEADBEEF);
    checkOutput("lw_p0 err", er, 0);
    checkOutput("lw_p0 latency", lat, 3);
    checkOutput("lw_p0 araddr", seen_araddr, 32'h100);
    checkOutput("lw_p0 other_rsp", oth, 0);

    aw_delay = 0; w_delay = 2;
    applyStimulus("sb_p1", 1, MEM_SB, 32'h203, 32'h000000A5, rd, er, lat, oth);
    checkOutput("sb_p1 awaddr", seen_awaddr, 32'h200);
    checkOutput("sb_p1 wstrb", seen_wstrb, 4'b1000);
    checkOutput("sb_p1 wdata", seen_wdata, 32'hA5A5A5A5);
    checkOutput("sb_p1 err", er, 0);
    checkOutput("sb_p1 rdata", rd, 0);
    checkOutput("sb_p1 latency", lat, 5);
    checkOutput("sb_p1 arvalid_cycles", arvalid_cycles, 0);
    checkOutput("sb_p1 other_rsp", oth, 0);

    w_delay = 0;
    applyStimulus("lh_mis", 0, MEM_LH, 32'h101, 32'h0, rd, er, lat, oth);
    checkOutput("lh_mis err", er, 1);
    checkOutput("lh_mis latency", lat, 2);
    checkOutput("lh_mis bus_valids", arvalid_cycles + awvalid_cycles, 0);

    s_rdata = 32'h11223344; s_rresp = 2'b10;
    applyStimulus("lb_slverr", 0, MEM_LB, 32'h302, 32'h0, rd, er, lat, oth);
    checkOutput("lb_slverr rdata", rd, 32'h00000022);
    checkOutput("lb_slverr err", er, 1);
    checkOutput("lb_slverr araddr", seen_araddr, 32'h300);

    s_rresp = 2'b00;
    applyStimulus("sh_p0", 0, MEM_SH, 32'h002, 32'h00001234, rd, er, lat, oth);
    checkOutput("sh_p0 wstrb", seen_wstrb, 4'b1100);
    checkOutput("sh_p0 wdata", seen_wdata, 32'h12341234);
    checkOutput("sh_p0 awaddr", seen_awaddr, 32'h0);
    checkOutput("sh_p0 latency", lat, 3);

    s_rdata = 32'hCAFEF00D;
    applyStimulus("lh_p1", 1, MEM_LH, 32'h206, 32'h0, rd, er, lat, oth);
    checkOutput("lh_p1 rdata", rd, 32'h0000CAFE);
    checkOutput("lh_p1 err", er, 0);
    checkOutput("lh_p1 other_rsp", oth, 0);

    applyStimulus("sw_mis", 1, MEM_SW, 32'h102, 32'h0, rd, er, lat, oth);
    checkOutput("sw_mis err", er, 1);
    checkOutput("sw_mis awvalid_cycles", awvalid_cycles, 0);

    applyStimulus("bad_op", 0, 3'd7, 32'h0, 32'h0, rd, er, lat, oth);
    checkOutput("bad_op err", er, 1);
    checkOutput("bad_op bus_valids", arvalid_cycles + awvalid_cycles, 0);

    aw_delay = 2; w_delay = 0; s_bresp = 2'b11;
    applyStimulus("sw_berr", 0, MEM_SW, 32'h10, 32'h89ABCDEF, rd, er, lat, oth);
    checkOutput("sw_berr err", er, 1);
    checkOutput("sw_berr wstrb", seen_wstrb, 4'b1111);
    checkOutput("sw_berr wdata", seen_wdata, 32'h89ABCDEF);
    checkOutput("sw_berr awaddr", seen_awaddr, 32'h10);
    checkOutput("sw_berr latency", lat, 5);
    aw_delay = 0; s_bresp = 2'b00;

`ifdef AXI_TIMEOUT_EN
    ar_delay = 1000;
    applyStimulus("tmo", 0, MEM_LW, 32'h500, 32'h0, rd, er, lat, oth);
    checkOutput("tmo err", er, 1);
    checkOutput("tmo arvalid_cycles", arvalid_cycles, 8);
    checkOutput("tmo latency", lat, 9);
    ar_delay = 0;
`endif

    // Reset in the middle of a store whose W beat is held off
    w_delay = 1000;
    seen = 0;
    @(negedge clock);
    req1_valid = 1; req1_op = MEM_SW; req1_addr = 32'h40; req1_wdata = 32'h1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = awvalid;
    end
    req1_valid = 0;
    checkOutput("midwr awvalid_seen", seen, 1);
    repeat (2) @(negedge clock);
    checkOutput("midwr wvalid_before", wvalid, 1);
    reset = 1;
    @(negedge clock);
    checkOutput("midwr valids_after_reset", {arvalid, awvalid, wvalid, rready, bready, rsp0_valid, rsp1_valid}, 0);
    reset = 0;
    w_delay = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      seen = seen | rsp0_valid | rsp1_valid;
    end
    checkOutput("midwr no_rsp", seen, 0);

    // Continuous contention on the round-robin instance
    grant_q.delete();
    @(negedge clock);
    req0_valid = 1; req0_op = MEM_LW; req0_addr = 32'h0;
    req1_valid = 1; req1_op = MEM_LW; req1_addr = 32'h4;
    for (int i = 0; i < 60 && grant_q.size() < 4; i++) @(negedge clock);
    req0_valid = 0; req1_valid = 0;
    checkOutput("rr grant_count", grant_q.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      checkOutput($sformatf("rr grant%0d", i), grant_q[i], i % 2);
    repeat (8) @(negedge clock);

    // Fixed priority: port 1 only gets in once port 0 lets go
    p_req0_valid = 1; p_req1_valid = 1;
    repeat (40) @(negedge clock);
    checkOutput("prio p1_while_p0", p1_while_p0, 0);
    checkOutput("prio p0_grants", p0_grants >= 8, 1);
    p_req0_valid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock); #1;
      seen = p_ready1;
    end
    p_req1_valid = 0;
    checkOutput("prio p1_after_release", seen, 1);
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
